usb_cmd_parser: RTL and testbench



---
 rtl/usb_cmd_parser.sv | 194 +++++++++++++++++++
 tb/tb_usb_cmd_parser.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_cmd_parser.sv
// rtl/usb_cmd_parser.sv - 5-byte command frame parser bridging a USB FIFO byte stream to a register bus
// Optional inter-byte timeout is compiled in with CMD_TIMEOUT_EN.
module usb_cmd_parser #(
    parameter int unsigned ADDR_W         = 8,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy
);

    typedef enum logic [3:0] {
        S_HUNT, S_CMD, S_ADDR, S_DATA, S_CHK, S_EXEC, S_RDWAIT, S_RSP0, S_RSP1, S_RSP2
    } state_t;

    localparam logic [7:0] CMD_WRITE   = 8'h01;
    localparam logic [7:0] CMD_READ    = 8'h02;
    localparam logic [7:0] ST_OK       = 8'h00;
    localparam logic [7:0] ST_BAD_CHK  = 8'h01;
    localparam logic [7:0] ST_BAD_CMD  = 8'h02;
    localparam logic [7:0] ST_BAD_ADDR = 8'h03;
    localparam logic [8:0] ADDR_LIMIT  = 9'(1 << ADDR_W);

    if (ADDR_W < 1 || ADDR_W > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("usb_cmd_parser: unsupported parameter values");
    end

    state_t            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        status_q, status_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              rx_ready_q, rx_ready_d;
    logic              reg_we_q, reg_we_d;
    logic              reg_re_q, reg_re_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [7:0]        reg_wdata_q, reg_wdata_d;
    logic [7:0]        frame_status;
    logic              rx_acc;
    logic              tx_acc;

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    assign rx_acc = rx_valid && rx_ready_q;
    assign tx_acc = tx_valid && tx_ready;

    // rx_data here is the CHK byte; only consumed when accepted in S_CHK
    always_comb begin
        if ((cmd_q ^ addr_q ^ data_q) != rx_data) begin
            frame_status = ST_BAD_CHK;
        end else if (cmd_q != CMD_WRITE && cmd_q != CMD_READ) begin
            frame_status = ST_BAD_CMD;
        end else if ({1'b0, addr_q} >= ADDR_LIMIT) begin
            frame_status = ST_BAD_ADDR;
        end else begin
            frame_status = ST_OK;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        data_d      = data_q;
        status_d    = status_q;
        rdata_d     = rdata_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
`ifdef CMD_TIMEOUT_EN
        tmo_d       = '0;
`endif
        case (state_q)
            S_HUNT: if (rx_acc && rx_data == SYNC_BYTE) state_d = S_CMD;
            S_CMD: if (rx_acc) begin
                cmd_d   = rx_data;
                state_d = S_ADDR;
            end
            S_ADDR: if (rx_acc) begin
                addr_d  = rx_data;
                state_d = S_DATA;
            end
            S_DATA: if (rx_acc) begin
                data_d  = rx_data;
                state_d = S_CHK;
            end
            S_CHK: if (rx_acc) begin
                // Strobes are registered here so they land in the EXEC cycle
                state_d  = S_EXEC;
                status_d = frame_status;
                rdata_d  = 8'h00;
                if (frame_status == ST_OK) begin
                    reg_addr_d = addr_q[ADDR_W-1:0];
                    if (cmd_q == CMD_WRITE) begin
                        reg_we_d    = 1'b1;
                        reg_wdata_d = data_q;
                        rdata_d     = data_q;
                    end else begin
                        reg_re_d = 1'b1;
                    end
                end
            end
            S_EXEC: state_d = (status_q == ST_OK && cmd_q == CMD_READ) ? S_RDWAIT : S_RSP0;
            S_RDWAIT: begin
                rdata_d = reg_rdata;
                state_d = S_RSP0;
            end
            S_RSP0: if (tx_acc) state_d = S_RSP1;
            S_RSP1: if (tx_acc) state_d = S_RSP2;
            S_RSP2: if (tx_acc) state_d = S_HUNT;
            default: state_d = S_HUNT;
        endcase
`ifdef CMD_TIMEOUT_EN
        if (state_q inside {S_CMD, S_ADDR, S_DATA, S_CHK} && !rx_acc) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_HUNT;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
`endif
        rx_ready_d = state_d inside {S_HUNT, S_CMD, S_ADDR, S_DATA, S_CHK};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_HUNT;
            cmd_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            status_q    <= '0;
            rdata_q     <= '0;
            rx_ready_q  <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
`ifdef CMD_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            status_q    <= status_d;
            rdata_q     <= rdata_d;
            rx_ready_q  <= rx_ready_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
`ifdef CMD_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    always_comb begin
        tx_data = 8'h00;
        case (state_q)
            S_RSP0:  tx_data = status_q;
            S_RSP1:  tx_data = addr_q;
            S_RSP2:  tx_data = rdata_q;
            default: tx_data = 8'h00;
        endcase
    end

    assign tx_valid  = state_q inside {S_RSP0, S_RSP1, S_RSP2};
    assign busy      = state_q inside {S_ADDR, S_DATA, S_CHK, S_EXEC, S_RDWAIT, S_RSP0, S_RSP1, S_RSP2};
    assign rx_ready  = rx_ready_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;

endmodule

// File: tb/tb_usb_cmd_parser.sv
// tb/tb_usb_cmd_parser.sv - self-checking bench for usb_cmd_parser against a frame-level model
module tb_usb_cmd_parser;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int TMO = 20;
    localparam int MAIN_AW = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [1:0] rx_valid = 2'b00;
    logic       tx_ready = 1'b1;
    logic [7:0] reg_rdata = 8'hEE;

    logic       rx_ready, tx_valid, reg_we, reg_re, busy;
    logic [7:0] tx_data, reg_addr, reg_wdata;
    logic       rx_ready4, tx_valid4, reg_we4, reg_re4, busy4;
    logic [7:0] tx_data4, reg_wdata4;
    logic [3:0] reg_addr4;

    always #5 clk = ~clk;

    usb_cmd_parser #(.ADDR_W(MAIN_AW), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)) u_dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid[0]), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy)
    );

    usb_cmd_parser #(.ADDR_W(4), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)) u_dut4 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid[1]), .rx_ready(rx_ready4),
        .tx_data(tx_data4), .tx_valid(tx_valid4), .tx_ready(tx_ready), .reg_addr(reg_addr4),
        .reg_wdata(reg_wdata4), .reg_we(reg_we4), .reg_re(reg_re4), .reg_rdata(reg_rdata), .busy(busy4)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: the register map, the partially collected frame and the
    // response still owed, all indexed by bench cycle number.
    logic [7:0] mmem [256];
    logic [7:0] fb [$];
    logic [7:0] exp_rsp [$];
    logic [7:0] got_rsp [$];
    logic [7:0] got4 [$];
    bit         collecting, m_busy, m_exec, after_rst;
    bit         exp_we, exp_re, exp_tv, exp_rdy;
    logic [7:0] exp_addr, exp_wdata;
    int         cyc = 0, strobe_cyc = -1, tx_start = 0, idle = 0;
    int         we_cnt = 0, re_cnt = 0;
    logic [7:0] last_waddr, last_wdata;

    function automatic void model_reset();
        collecting = 0; m_busy = 0; m_exec = 0; idle = 0; strobe_cyc = -1;
        fb.delete();
        exp_rsp.delete();
    endfunction

    function automatic void finish_frame();
        logic [7:0] c, a, d, k, st, rd;
        c = fb[0]; a = fb[1]; d = fb[2]; k = fb[3];
        if ((c ^ a ^ d) != k) st = 8'h01;
        else if (c != 8'h01 && c != 8'h02) st = 8'h02;
        else if (int'(a) >= (1 << MAIN_AW)) st = 8'h03;
        else st = 8'h00;
        exp_we = (st == 8'h00) && (c == 8'h01);
        exp_re = (st == 8'h00) && (c == 8'h02);
        exp_addr = a; exp_wdata = d;
        rd = (st != 8'h00) ? 8'h00 : (exp_we ? d : mmem[a]);
        if (exp_we) mmem[a] = d;
        strobe_cyc = cyc + 1;
        tx_start = cyc + (exp_re ? 3 : 2);
        exp_rsp.push_back(st); exp_rsp.push_back(a); exp_rsp.push_back(rd);
        m_exec = 1;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (!collecting) begin
            if (b == SYNC) begin collecting = 1; idle = 0; fb.delete(); end
        end else begin
            idle = 0;
            fb.push_back(b);
            if (fb.size() == 1) m_busy = 1;
            if (fb.size() == 4) begin finish_frame(); collecting = 0; end
        end
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            chk("reset_outputs", 32'({rx_ready, tx_valid, reg_we, reg_re, busy, tx_data, reg_addr, reg_wdata}), 32'h0);
            model_reset();
            after_rst = 1;
        end else begin
            exp_rdy = !after_rst && !m_exec;
            exp_tv  = (exp_rsp.size() > 0) && (cyc >= tx_start);
            chk("rx_ready", 32'(rx_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("reg_we", 32'(reg_we), 32'(cyc == strobe_cyc && exp_we));
            chk("reg_re", 32'(reg_re), 32'(cyc == strobe_cyc && exp_re));
            if (cyc == strobe_cyc && (exp_we || exp_re)) begin
                chk("reg_addr", 32'(reg_addr), 32'(exp_addr));
                if (exp_we) chk("reg_wdata", 32'(reg_wdata), 32'(exp_wdata));
            end
            chk("tx_valid", 32'(tx_valid), 32'(exp_tv));
            if (exp_tv) chk("tx_data", 32'(tx_data), 32'(exp_rsp[0]));
            if (tx_valid && tx_ready) begin
                got_rsp.push_back(tx_data);
                if (exp_tv) begin
                    void'(exp_rsp.pop_front());
                    if (exp_rsp.size() == 0) begin m_exec = 0; m_busy = 0; end
                end
            end
            if (reg_we) begin we_cnt++; last_waddr = reg_addr; last_wdata = reg_wdata; end
            if (reg_re) re_cnt++;
            if (rx_valid[0] && rx_ready) model_byte(rx_data);
`ifdef CMD_TIMEOUT_EN
            else if (collecting) begin
                idle++;
                if (idle == TMO) begin collecting = 0; m_busy = 0; end
            end
`endif
            after_rst = 0;
        end
    end

    // Register-bus slave: its own storage, read data valid for exactly one cycle.
    logic [7:0] slave_mem [256];
    bit         rd_pend = 0;
    logic [7:0] rd_addr;
    int         n_strobe4 = 0;
    logic [3:0] last_addr4;
    logic [7:0] last_wdata4;

    always @(negedge clk) begin
        if (rst && reg_we) slave_mem[reg_addr] = reg_wdata;
        if (rst && reg_re) begin rd_pend = 1; rd_addr = reg_addr; end
        if (rst && tx_valid4 && tx_ready) got4.push_back(tx_data4);
        if (rst && (reg_we4 || reg_re4)) begin n_strobe4++; last_addr4 = reg_addr4; last_wdata4 = reg_wdata4; end
    end

    always begin
        @(posedge clk);
        #1;
        if (rd_pend) begin reg_rdata = slave_mem[rd_addr]; rd_pend = 0; end
        else reg_rdata = 8'hEE;
    end

    task automatic send_byte(input int d, input logic [7:0] b);
        int n = 0;
        bit acc = 0;
        rx_data = b;
        rx_valid[d] = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = (d == 0) ? rx_ready : rx_ready4;
            @(posedge clk);
            #1;
            n++;
        end
        rx_valid[d] = 1'b0;
        chk("rx_accept", 32'(acc), 32'd1);
    endtask

    task automatic send5(input int d, input logic [7:0] b0, b1, b2, b3, b4);
        send_byte(d, b0); send_byte(d, b1); send_byte(d, b2); send_byte(d, b3); send_byte(d, b4);
    endtask

    task automatic wait_rsp(input int d, input int n);
        int k = 0;
        while (((d == 0) ? got_rsp.size() : got4.size()) < n && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("rsp_count", 32'((d == 0) ? got_rsp.size() : got4.size()), 32'(n));
    endtask

    task automatic expect_rsp(input int d, input string name, input logic [7:0] a, b, c);
        logic [7:0] want [3];
        logic [7:0] v;
        want[0] = a; want[1] = b; want[2] = c;
        for (int i = 0; i < 3; i++) begin
            v = 'x;
            if (d == 0 && got_rsp.size() > 0) v = got_rsp.pop_front();
            if (d == 1 && got4.size() > 0) v = got4.pop_front();
            chk(name, 32'(v), 32'(want[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int we0;
        for (int i = 0; i < 256; i++) begin
            mmem[i] = 8'(i) ^ 8'h4A;
            slave_mem[i] = 8'(i) ^ 8'h4A;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rdy_before_first_edge", 32'(rx_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rdy_after_first_edge", 32'(rx_ready), 32'd1);

        // Read of 0x10 (slave holds 0x5A) with RSP1 stalled for five cycles
        tx_ready = 1'b0;
        send5(0, 8'hA5, 8'h02, 8'h10, 8'h00, 8'h12);
        n = 0;
        while (!tx_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("read_tx_latency", 32'(n), 32'd2);
        chk("rsp0_data", 32'(tx_data), 32'h00);
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_hold", 32'({tx_valid, tx_data}), 32'h110);
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b1;
        wait_rsp(0, 3);
        expect_rsp(0, "read_rsp", 8'h00, 8'h10, 8'h5A);
        chk("read_strobe_count", 32'(re_cnt), 32'd1);

        we0 = we_cnt;
        send5(0, 8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D);
        wait_rsp(0, 3);
        expect_rsp(0, "write_rsp", 8'h00, 8'h10, 8'h3C);
        chk("write_strobe", 32'({8'(we_cnt - we0), last_waddr, last_wdata}), 32'h01103C);

        send5(0, 8'hA5, 8'h02, 8'h10, 8'h00, 8'h12);
        wait_rsp(0, 3);
        expect_rsp(0, "readback_rsp", 8'h00, 8'h10, 8'h3C);

        we0 = we_cnt;
        send5(0, 8'hA5, 8'h01, 8'h10, 8'h3C, 8'h00);
        wait_rsp(0, 3);
        expect_rsp(0, "badchk_rsp", 8'h01, 8'h10, 8'h00);
        send5(0, 8'hA5, 8'h07, 8'h00, 8'h00, 8'h07);
        wait_rsp(0, 3);
        expect_rsp(0, "badcmd_rsp", 8'h02, 8'h00, 8'h00);
        chk("error_no_strobe", 32'(we_cnt - we0), 32'd0);

        send_byte(0, 8'h00);
        send_byte(0, 8'hFF);
        send5(0, 8'hA5, 8'h01, 8'h20, 8'h11, 8'h30);
        wait_rsp(0, 3);
        expect_rsp(0, "resync_rsp", 8'h00, 8'h20, 8'h11);
        chk("resync_strobe", 32'({last_waddr, last_wdata}), 32'h2011);

        send5(0, 8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h01);
        wait_rsp(0, 3);
        expect_rsp(0, "sync_as_data_rsp", 8'h00, 8'hA5, 8'hA5);

        // Second frame is back-pressured until the first response drains
        send5(0, 8'hA5, 8'h01, 8'h33, 8'h44, 8'h76);
        send5(0, 8'hA5, 8'h02, 8'h33, 8'h00, 8'h31);
        wait_rsp(0, 6);
        expect_rsp(0, "b2b_write_rsp", 8'h00, 8'h33, 8'h44);
        expect_rsp(0, "b2b_read_rsp", 8'h00, 8'h33, 8'h44);

        we0 = we_cnt;
        send_byte(0, 8'hA5);
        send_byte(0, 8'h01);
        send_byte(0, 8'h40);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_in_reset", 32'(busy), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        send5(0, 8'hA5, 8'h01, 8'h40, 8'h55, 8'h14);
        wait_rsp(0, 3);
        expect_rsp(0, "after_reset_rsp", 8'h00, 8'h40, 8'h55);
        chk("after_reset_strobes", 32'(we_cnt - we0), 32'd1);

`ifdef CMD_TIMEOUT_EN
        send_byte(0, 8'hA5);
        send_byte(0, 8'h01);
        repeat (25) @(posedge clk);
        #1;
        chk("timeout_busy", 32'(busy), 32'd0);
        send5(0, 8'hA5, 8'h01, 8'h05, 8'h07, 8'h03);
        wait_rsp(0, 3);
        expect_rsp(0, "timeout_rsp", 8'h00, 8'h05, 8'h07);
        chk("timeout_strobe", 32'({last_waddr, last_wdata}), 32'h0507);
`endif

        send5(1, 8'hA5, 8'h01, 8'h10, 8'h00, 8'h11);
        wait_rsp(1, 3);
        expect_rsp(1, "aw4_range_rsp", 8'h03, 8'h10, 8'h00);
        chk("aw4_no_strobe", 32'(n_strobe4), 32'd0);
        send5(1, 8'hA5, 8'h01, 8'h05, 8'h07, 8'h03);
        wait_rsp(1, 3);
        expect_rsp(1, "aw4_write_rsp", 8'h00, 8'h05, 8'h07);
        chk("aw4_strobe", 32'({4'(n_strobe4), last_addr4, last_wdata4}), 32'h1507);

        repeat (5) @(posedge clk);
        #1;
        chk("model_drained", 32'(exp_rsp.size() + got_rsp.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
